// File: rtl/ec_scalar_mult_pkg.sv
// Shared types for the elliptic-curve scalar multiplier: curve point with
// infinity flag, sequencer states and the per-step point operation.
package biblioteca_mea;
  localparam int EC_W  = 16;
  localparam int EC_KW = 16;

  typedef struct packed {
    logic [EC_W-1:0] coord_x;
    logic [EC_W-1:0] coord_y;
    logic            inf;
  } punct;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_INV,
    ST_LAMBDA,
    ST_X3,
    ST_Y3,
    ST_NEXT,
    ST_FINISH
  } ec_state_t;

  typedef enum logic {
    OP_DBL,
    OP_ADD
  } ec_op_t;
endpackage

// File: rtl/ec_scalar_mult_if.sv
// Request/result bundle between a controller and the scalar multiplier.
interface ec_scalar_mult_if
  import biblioteca_mea::*;
#(
  parameter int W  = EC_W,
  parameter int KW = EC_KW
);
  logic          start;
  logic [KW-1:0] k;
  logic [W-1:0]  px;
  logic [W-1:0]  py;
  logic [W-1:0]  p_mod;
  logic [W-1:0]  a_coef;
  logic          busy;
  logic          done;
  logic [W-1:0]  rx;
  logic [W-1:0]  ry;
  logic          r_inf;

  modport master (output start, k, px, py, p_mod, a_coef,
                  input  busy, done, rx, ry, r_inf);
  modport slave  (input  start, k, px, py, p_mod, a_coef,
                  output busy, done, rx, ry, r_inf);
endinterface

// File: rtl/ec_scalar_mult_mod_inv.sv
// Binary extended-Euclid inverse mod an odd prime; one halving or
// subtract-and-halve step per cycle, so each step shortens u or v by a bit.
module ec_mod_inv
  import biblioteca_mea::*;
#(
  parameter int W = EC_W
) (
  input  logic         CLK100MHZ,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] val,
  input  logic [W-1:0] p_mod,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] inv
);
  logic [W-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, p_q, p_d;
  logic         busy_q, busy_d;

  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    return (a >= b) ? (a - b) : (a + (m - b));
  endfunction

  // Invariants: x1*val == u and x2*val == v (mod p); stop when either reaches 1.
  assign done = busy_q && ((u_q == W'(1)) || (v_q == W'(1)));
  assign inv  = (u_q == W'(1)) ? x1_q : x2_q;
  assign busy = busy_q;

  always_comb begin
    u_d    = u_q;
    v_d    = v_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    p_d    = p_q;
    busy_d = busy_q;
    if (start) begin
      u_d    = val;
      v_d    = p_mod;
      x1_d   = W'(1);
      x2_d   = '0;
      p_d    = p_mod;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
      end else if (!u_q[0]) begin
        u_d  = u_q >> 1;
        x1_d = half_mod(x1_q, p_q);
      end else if (!v_q[0]) begin
        v_d  = v_q >> 1;
        x2_d = half_mod(x2_q, p_q);
      end else if (u_q >= v_q) begin
        u_d  = (u_q - v_q) >> 1;
        x1_d = half_mod(sub_mod(x1_q, x2_q, p_q), p_q);
      end else begin
        v_d  = (v_q - u_q) >> 1;
        x2_d = half_mod(sub_mod(x2_q, x1_q, p_q), p_q);
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      p_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      u_q    <= u_d;
      v_q    <= v_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      p_q    <= p_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/ec_scalar_mult.sv
// Affine left-to-right double-and-add scalar multiplier R = k*P over GF(p),
// one field operation per FSM state with a shared sequential inverter.
module ec_scalar_mult
  import biblioteca_mea::*;
#(
  parameter int W  = EC_W,   // must equal EC_W: the point struct is sized by the package
  parameter int KW = EC_KW
) (
  input logic             CLK100MHZ,
  input logic             RST,
  ec_scalar_mult_if.slave bus
);
  localparam int   IW    = $clog2(KW);
  localparam punct R_INF = '{coord_x: '0, coord_y: '0, inf: 1'b1};

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    prod = prod % {{W{1'b0}}, m};
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    return (a >= b) ? (a - b) : (a + (m - b));
  endfunction

  ec_state_t     state_q, state_d;
  ec_op_t        op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  px_q, px_d, py_q, py_d, p_q, p_d, a_q, a_d;
  logic [W-1:0]  num_q, num_d, x2_q, x2_d, inv_q, inv_d, lam_q, lam_d, x3_q, x3_d;
  logic [W-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic          rinf_q, rinf_d;
  punct          r_q, r_d;

  logic          inv_start, inv_busy, inv_done, as_dbl;
  logic [W-1:0]  den, inv_res, neg_py;

  ec_mod_inv #(.W(W)) u_inv (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .start     (inv_start),
    .val       (den),
    .p_mod     (p_q),
    .busy      (inv_busy),
    .done      (inv_done),
    .inv       (inv_res)
  );

  assign neg_py = (py_q == '0) ? '0 : (p_q - py_q);
  // An ADD step whose accumulator already equals P must use the tangent slope.
  assign as_dbl = (op_q == OP_DBL) || ((r_q.coord_x == px_q) && (r_q.coord_y == py_q));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    k_d       = k_q;
    px_d      = px_q;
    py_d      = py_q;
    p_d       = p_q;
    a_d       = a_q;
    r_d       = r_q;
    num_d     = num_q;
    x2_d      = x2_q;
    inv_d     = inv_q;
    lam_d     = lam_q;
    x3_d      = x3_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    rinf_d    = rinf_q;
    inv_start = 1'b0;
    den       = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_d     = bus.k;
          px_d    = bus.px;
          py_d    = bus.py;
          p_d     = bus.p_mod;
          a_d     = bus.a_coef;
          r_d     = R_INF;
          idx_d   = IW'(KW - 1);
          op_d    = OP_DBL;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_NEXT;
        if (r_q.inf) begin
          r_d = (op_q == OP_DBL) ? R_INF : '{coord_x: px_q, coord_y: py_q, inf: 1'b0};
        end else if ((op_q == OP_DBL) && (r_q.coord_y == '0)) begin
          r_d = R_INF;
        end else if ((op_q == OP_ADD) && (r_q.coord_x == px_q) && (r_q.coord_y == neg_py)) begin
          r_d = R_INF;
        end else begin
          inv_start = 1'b1;
          state_d   = ST_INV;
          if (as_dbl) begin
            num_d = mod_add(mod_mul(mod_mul(r_q.coord_x, r_q.coord_x, p_q), W'(3), p_q), a_q, p_q);
            den   = mod_add(r_q.coord_y, r_q.coord_y, p_q);
            x2_d  = r_q.coord_x;
          end else begin
            num_d = mod_sub(py_q, r_q.coord_y, p_q);
            den   = mod_sub(px_q, r_q.coord_x, p_q);
            x2_d  = px_q;
          end
        end
      end
      ST_INV: begin
        if (inv_busy && inv_done) begin
          inv_d   = inv_res;
          state_d = ST_LAMBDA;
        end
      end
      ST_LAMBDA: begin
        lam_d   = mod_mul(num_q, inv_q, p_q);
        state_d = ST_X3;
      end
      ST_X3: begin
        x3_d    = mod_sub(mod_sub(mod_mul(lam_q, lam_q, p_q), r_q.coord_x, p_q), x2_q, p_q);
        state_d = ST_Y3;
      end
      ST_Y3: begin
        r_d.coord_y = mod_sub(mod_mul(lam_q, mod_sub(r_q.coord_x, x3_q, p_q), p_q),
                              r_q.coord_y, p_q);
        r_d.coord_x = x3_q;
        r_d.inf     = 1'b0;
        state_d     = ST_NEXT;
      end
      ST_NEXT: begin
        if ((op_q == OP_DBL) && k_q[idx_q]) begin
          op_d    = OP_ADD;
          state_d = ST_SETUP;
        end else begin
          op_d = OP_DBL;
          if (idx_q == '0) begin
            // Results are published on entry to FINISH so they change only with done.
            rx_d    = r_q.coord_x;
            ry_d    = r_q.coord_y;
            rinf_d  = r_q.inf;
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DBL;
      idx_q   <= '0;
      k_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      p_q     <= '0;
      a_q     <= '0;
      r_q     <= '0;
      num_q   <= '0;
      x2_q    <= '0;
      inv_q   <= '0;
      lam_q   <= '0;
      x3_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      px_q    <= px_d;
      py_q    <= py_d;
      p_q     <= p_d;
      a_q     <= a_d;
      r_q     <= r_d;
      num_q   <= num_d;
      x2_q    <= x2_d;
      inv_q   <= inv_d;
      lam_q   <= lam_d;
      x3_q    <= x3_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rinf_q  <= rinf_d;
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_FINISH);
  assign bus.rx    = rx_q;
  assign bus.ry    = ry_q;
  assign bus.r_inf = rinf_q;
endmodule

// File: doc/ec_scalar_mult.md
# ec_scalar_mult

- Sequential elliptic-curve scalar multiplier over a prime field GF(p). It computes R = k·P on y² = x³ + a·x + b (mod p) using affine coordinates and left-to-right double-and-add.
- Modulus, curve coefficient and point are runtime inputs; field width and scalar width are parameters.
- It replaces the combinational point-multiply function at the top level. Its result feeds the 7-segment display path, and a start/done handshake replaces the slow-clock trigger.

## Interface
- `W`, 16: width of field elements (p, a, coordinates); p < 2^(W-1).
- `KW`, 16: scalar width.
- `CLK100MHZ` in 1: single clock.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `k` in KW: scalar, unsigned.
- `px`, `py` in W: input point P, each already reduced mod p.
- `p_mod` in W: odd prime modulus, > 3.
- `a_coef` in W: curve coefficient a, < p_mod. b is implied by P and is not needed.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse; result valid in this cycle.
- `rx`, `ry` out W: result coordinates; 0 when `r_inf` = 1.
- `r_inf` out 1: result is the point at infinity O.

## Operation
- **Accept.** In IDLE, `start` = 1 latches k, px, py, p_mod and a_coef. Initial state: R = O, bit index i = KW-1.
- **Per bit.** For each bit, DBL (R = 2R), then ADD (R = R + P) if k[i] = 1. Then i decrements; after i = 0, go to FINISH.
- **Special cases**, resolved in the SETUP cycle with no inversion:
  - DBL with R = O, or with Ry = 0: result is O.
  - ADD with R = O: result is P.
  - ADD with Rx = Px and Ry = (p − Py) mod p: result is O.
  - ADD with R = P: performed as DBL.
- **General slope.**
  - DBL: num = 3·Rx² + a, den = 2·Ry.
  - ADD: num = Py − Ry, den = Px − Rx.
  - λ = num · den⁻¹ mod p.
  - x3 = λ² − x1 − x2.
  - y3 = λ·(x1 − x3) − y1.
  - All terms are reduced into [0, p−1]; subtraction adds p when the result is negative.
  - Products are 2W wide before reduction.
- **FSM states.** IDLE → SETUP → INV → LAMBDA → X3 → Y3 → NEXT → (SETUP | FINISH) → IDLE.
  - SETUP forms num/den or a special-case result. A special case goes directly to NEXT.
  - NEXT selects ADD for the same bit when k[i] = 1 and ADD has not been done; otherwise it decrements i.
  - FINISH copies R into rx, ry and r_inf and pulses `done`.
- **Handshake.**
  - `start` while busy is ignored.
  - `rx`, `ry` and `r_inf` change only in the `done` cycle and are held until the next `done`.
- **Reset**, including mid-operation:
  - State → IDLE.
  - `busy` = 0, `done` = 0, `rx` = `ry` = 0, `r_inf` = 0.
  - The operation in progress is discarded and no `done` is produced.
- **k = 0:** every step takes a special-case path. Result O (r_inf = 1, rx = ry = 0).

## Timing
- Accepted start at cycle t: `busy` = 1 at t+1.
- SETUP: 1 cycle.
- INV: at most 2W+2 cycles, data-dependent.
- LAMBDA, X3, Y3, NEXT: 1 cycle each.
- Special-case step: 2 cycles (SETUP, NEXT).
- Worst-case latency: 2·KW·(2W+7) + 2 cycles.
- `done` and `busy` fall in the same cycle. A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `biblioteca_mea`:
  - the `punct` struct (coord_x, coord_y) plus a new `inf` bit;
  - FSM state enum `ec_state_t`;
  - op enum `ec_op_t` (DBL, ADD).
- Sub-module `ec_mod_inv`: binary extended-Euclid modular inverse.
  - Ports: `CLK100MHZ`, `RST`, `start`, `val`[W], `p_mod`[W], `busy`, `done`, `inv`[W].
  - `inv` = val⁻¹ mod p.
  - Completes in ≤ 2W+2 cycles.
  - `val` = 0 is never issued; den = 0 is trapped in SETUP.
- Top-level change: the display shows 10000·rx + ry, with a separate indication when r_inf = 1.

## Test plan
Curve p = 29, a = 4, P = (1,5). The point order is 37.
- k = 1 → rx = 1, ry = 5, r_inf = 0.
- k = 2 → (4,19); k = 3 → (20,3).
- k = 36 → (1,24); k = 37 → r_inf = 1, rx = ry = 0.
- k = 0 → r_inf = 1.
  - Latency = 2·KW + 2 cycles: 16 DBL steps at 2 cycles each, plus the accept and FINISH cycles.
- Pulse `start` again mid-run with k = 2 while a k = 3 run is busy → that start is ignored; single `done` with result (20,3).
- Assert `RST` mid-run → `busy` = 0 next cycle; no `done`; outputs = 0.
  - A fresh start with k = 2 then returns (4,19).
